// File: rtl/seven_seg_scan.sv
// Time-multiplexed N-digit hex seven-segment driver with double-buffered display data.
// Staged data is committed only at a frame boundary so a scanned frame never tears.
module seven_seg_scan #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] A,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_blank,
    input  logic                    load,
    output logic [6:0]              Y,
    output logic                    DP,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic                    frame_done
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0]         PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_POL    = ACTIVE_LOW ? '1 : '0;
    localparam logic [NUM_DIGITS-1:0] AN_POL     = ACTIVE_LOW ? '1 : '0;

    logic [PW-1:0]           presc;
    logic [IW-1:0]           idx;
    logic                    tick;
    logic                    frame;

    logic [4*NUM_DIGITS-1:0] stg_a;
    logic [NUM_DIGITS-1:0]   stg_dp;
    logic [NUM_DIGITS-1:0]   stg_en;
    logic                    stg_lz;
    logic                    pending;

    logic [4*NUM_DIGITS-1:0] com_a;
    logic [NUM_DIGITS-1:0]   com_dp;
    logic [NUM_DIGITS-1:0]   com_en;
    logic                    com_lz;

    logic [NUM_DIGITS-1:0]   blank;
    logic                    all_zero;
    logic [3:0]              nib;
    logic                    lit;
    logic [NUM_DIGITS-1:0]   an_hot;
    logic [6:0]              seg_nx;
    logic                    dp_nx;

    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_seg = 7'h3F;
            4'h1: hex_seg = 7'h06;
            4'h2: hex_seg = 7'h5B;
            4'h3: hex_seg = 7'h4F;
            4'h4: hex_seg = 7'h66;
            4'h5: hex_seg = 7'h6D;
            4'h6: hex_seg = 7'h7D;
            4'h7: hex_seg = 7'h07;
            4'h8: hex_seg = 7'h7F;
            4'h9: hex_seg = 7'h6F;
            4'hA: hex_seg = 7'h77;
            4'hB: hex_seg = 7'h7C;
            4'hC: hex_seg = 7'h39;
            4'hD: hex_seg = 7'h5E;
            4'hE: hex_seg = 7'h79;
            4'hF: hex_seg = 7'h71;
        endcase
    endfunction

    assign tick       = (presc == PRESC_LAST);
    assign frame      = tick && (idx == IDX_LAST);
    assign frame_done = frame & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
        end else if (tick) begin
            presc <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // A load landing on the boundary edge bypasses staging straight into the committed set.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_a   <= '0;
            stg_dp  <= '0;
            stg_en  <= '0;
            stg_lz  <= 1'b0;
            pending <= 1'b0;
            com_a   <= '0;
            com_dp  <= '0;
            com_en  <= '0;
            com_lz  <= 1'b0;
        end else begin
            if (load) begin
                stg_a  <= A;
                stg_dp <= dp_in;
                stg_en <= digit_en;
                stg_lz <= lz_blank;
            end
            if (frame && load) begin
                com_a   <= A;
                com_dp  <= dp_in;
                com_en  <= digit_en;
                com_lz  <= lz_blank;
                pending <= 1'b0;
            end else if (frame && pending) begin
                com_a   <= stg_a;
                com_dp  <= stg_dp;
                com_en  <= stg_en;
                com_lz  <= stg_lz;
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    // Walk down from the top digit; a digit is blanked while everything at or above it is zero.
    always_comb begin
        blank    = '0;
        all_zero = 1'b1;
        for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
            all_zero = all_zero & (com_a[4*i +: 4] == 4'h0);
            blank[i] = com_lz & all_zero;
        end
    end

    always_comb begin
        nib    = com_a[4*idx +: 4];
        lit    = com_en[idx] & ~blank[idx];
        an_hot = '0;
        if (lit) an_hot[idx] = 1'b1;
        seg_nx = lit ? hex_seg(nib) : '0;
        dp_nx  = lit & com_dp[idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            AN <= AN_POL;
            Y  <= SEG_POL;
            DP <= ACTIVE_LOW;
        end else begin
            AN <= an_hot ^ AN_POL;
            Y  <= seg_nx ^ SEG_POL;
            DP <= dp_nx ^ ACTIVE_LOW;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboarded bench for seven_seg_scan (4 digits, 4 clocks per slot, active-low pins),
// with directed per-slot checks for hex walk, blanking, tear-free update and reset.
module tb_seven_seg_scan;

    localparam int ND = 4;
    localparam int RD = 4;

    localparam logic [6:0] SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] A = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  digit_en = '0;
    logic        lz_blank = 1'b0;
    logic        load = 1'b0;
    logic [6:0]  Y;
    logic        DP;
    logic [3:0]  AN;
    logic        frame_done;

    int n_checks = 0;
    int n_pass   = 0;

    seven_seg_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .A(A), .dp_in(dp_in), .digit_en(digit_en),
        .lz_blank(lz_blank), .load(load), .Y(Y), .DP(DP), .AN(AN),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else n_pass++;
    endtask

    // Expected pin state {AN, Y, DP} for a digit slot, given committed display data.
    function automatic logic [11:0] model_out(input int idx, input logic [15:0] a,
                                              input logic [3:0] dp, input logic [3:0] en,
                                              input logic lz);
        int hi = -1;
        logic lit;
        logic [3:0] an = 4'hF;
        logic [3:0] n;
        for (int i = 0; i < ND; i++) if (a[4*i +: 4] != 4'h0) hi = i;
        lit = en[idx] && !(lz && idx > 0 && idx > hi);
        n = a[4*idx +: 4];
        if (lit) an[idx] = 1'b0;
        return {an, lit ? ~SEG[n] : 7'h7F, lit ? ~dp[idx] : 1'b1};
    endfunction

    int          m_pre = 0;
    int          m_idx = 0;
    logic [15:0] s_a = '0, c_a = '0;
    logic [3:0]  s_dp = '0, s_en = '0, c_dp = '0, c_en = '0;
    logic        s_lz = 1'b0, c_lz = 1'b0, m_pend = 1'b0;
    logic [11:0] sb [$];

    always @(posedge clk) begin
        sb.push_back(rst ? 12'hFFF : model_out(m_idx, c_a, c_dp, c_en, c_lz));
        if (rst) begin
            m_pre <= 0; m_idx <= 0; m_pend <= 1'b0;
            s_a <= '0; s_dp <= '0; s_en <= '0; s_lz <= 1'b0;
            c_a <= '0; c_dp <= '0; c_en <= '0; c_lz <= 1'b0;
        end else begin
            m_pre <= (m_pre == RD - 1) ? 0 : m_pre + 1;
            if (m_pre == RD - 1) m_idx <= (m_idx + 1) % ND;
            if (load) begin
                s_a <= A; s_dp <= dp_in; s_en <= digit_en; s_lz <= lz_blank;
            end
            if (m_pre == RD - 1 && m_idx == ND - 1 && load) begin
                c_a <= A; c_dp <= dp_in; c_en <= digit_en; c_lz <= lz_blank; m_pend <= 1'b0;
            end else if (m_pre == RD - 1 && m_idx == ND - 1 && m_pend) begin
                c_a <= s_a; c_dp <= s_dp; c_en <= s_en; c_lz <= s_lz; m_pend <= 1'b0;
            end else if (load) begin
                m_pend <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        logic [11:0] e;
        chk("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_an", 32'(AN), 32'(e[11:8]));
            chk("sb_y", 32'(Y), 32'(e[7:1]));
            chk("sb_dp", 32'(DP), 32'(e[0]));
        end
        chk("sb_fd", 32'(frame_done), 32'(m_pre == RD - 1 && m_idx == ND - 1 && !rst));
    end

    task automatic drive_load(input logic [15:0] a, input logic [3:0] dp,
                              input logic [3:0] en, input logic lz);
        @(negedge clk); #1;
        A = a; dp_in = dp; digit_en = en; lz_blank = lz; load = 1'b1;
        @(negedge clk); #1;
        load = 1'b0;
    endtask

    // Returns at the falling edge inside the cycle whose closing edge is the frame boundary.
    task automatic wait_frame();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = frame_done;
        end
        chk("frame_seen", 32'(seen), 1);
    endtask

    // Call just after the boundary edge; checks the first cycle of each slot of the new frame.
    task automatic check_slots(input string tag, input logic [15:0] ean,
                               input logic [27:0] ey, input logic [3:0] edp);
        for (int s = 0; s < ND; s++) begin
            repeat (s == 0 ? 1 : RD) @(posedge clk);
            @(negedge clk);
            chk($sformatf("%s_an%0d", tag, s), 32'(AN), 32'(ean[4*s +: 4]));
            chk($sformatf("%s_y%0d", tag, s), 32'(Y), 32'(ey[7*s +: 7]));
            chk($sformatf("%s_dp%0d", tag, s), 32'(DP), 32'(edp[s]));
        end
    endtask

    task automatic check_model(input string tag, input logic [15:0] a, input logic [3:0] dp,
                               input logic [3:0] en, input logic lz);
        logic [15:0] ean;
        logic [27:0] ey;
        logic [3:0]  edp;
        logic [11:0] o;
        for (int s = 0; s < ND; s++) begin
            o = model_out(s, a, dp, en, lz);
            ean[4*s +: 4] = o[11:8];
            ey[7*s +: 7]  = o[7:1];
            edp[s]        = o[0];
        end
        check_slots(tag, ean, ey, edp);
    endtask

    logic [15:0] walk [3] = '{16'h3210, 16'h7654, 16'hBA98};

    initial begin
        repeat (3) begin
            @(negedge clk);
            chk("rst_an", 32'(AN), 32'h0000000F);
            chk("rst_y", 32'(Y), 32'h0000007F);
            chk("rst_dp", 32'(DP), 1);
            chk("rst_fd", 32'(frame_done), 0);
        end
        #1 rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("dark_an", 32'(AN), 32'h0000000F);

        drive_load(16'hFEDC, 4'b0101, 4'hF, 1'b0);
        wait_frame(); @(posedge clk);
        check_slots("hexwalk", 16'h7BDE, {~7'h71, ~7'h79, ~7'h5E, ~7'h39}, 4'b1010);
        for (int k = 0; k < 3; k++) begin
            drive_load(walk[k], 4'h0, 4'hF, 1'b0);
            wait_frame(); @(posedge clk);
            check_model("hex", walk[k], 4'h0, 4'hF, 1'b0);
        end

        drive_load(16'h0050, 4'h0, 4'hF, 1'b1);
        wait_frame(); @(posedge clk);
        check_slots("lz50", 16'hFFDE, {7'h7F, 7'h7F, ~7'h6D, ~7'h3F}, 4'hF);
        drive_load(16'h0000, 4'h0, 4'hF, 1'b1);
        wait_frame(); @(posedge clk);
        check_slots("lz00", 16'hFFFE, {7'h7F, 7'h7F, 7'h7F, ~7'h3F}, 4'hF);

        wait_frame(); @(posedge clk);
        repeat (5) @(posedge clk);
        drive_load(16'h1234, 4'h0, 4'hF, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("tear_old_an", 32'(AN), 32'h0000000F);
        chk("tear_old_y", 32'(Y), 32'h0000007F);
        wait_frame(); @(posedge clk);
        check_slots("tear_new", 16'h7BDE, {~7'h06, ~7'h5B, ~7'h4F, ~7'h66}, 4'hF);

        wait_frame(); @(posedge clk);
        repeat (3) @(posedge clk);
        drive_load(16'h1111, 4'h0, 4'hF, 1'b0);
        drive_load(16'h5678, 4'h0, 4'hF, 1'b0);
        wait_frame(); @(posedge clk);
        check_model("lastwins", 16'h5678, 4'h0, 4'hF, 1'b0);

        wait_frame();
        #1;
        A = 16'hABCD; dp_in = 4'b1000; digit_en = 4'b1011; lz_blank = 1'b0; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        check_slots("bypass", 16'h7FDE, {~7'h77, 7'h7F, ~7'h39, ~7'h5E}, 4'b0111);
        wait_frame(); @(posedge clk);
        check_model("bypass_hold", 16'hABCD, 4'b1000, 4'b1011, 1'b0);

        wait_frame(); @(posedge clk);
        drive_load(16'h9999, 4'hF, 4'hF, 1'b0);
        repeat (6) @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_an", 32'(AN), 32'h0000000F);
        chk("midrst_y", 32'(Y), 32'h0000007F);
        chk("midrst_dp", 32'(DP), 1);
        chk("midrst_fd", 32'(frame_done), 0);
        #1 rst = 1'b0;
        wait_frame(); @(posedge clk);
        check_slots("postrst", 16'hFFFF, {4{7'h7F}}, 4'hF);
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1);
    end

endmodule
